counter_k: RTL and testbench

COUNTER_K -- requirements
Module: counter_k

---
 rtl/counter_k.sv | 72 +++++++
 tb/tb_counter_k.sv | 121 ++++++++++++
 2 files changed

// File: rtl/counter_k.sv
// counter_k -- saturating unsigned up/down counter.
//
// Counts push requests up and pop requests down. The count stops at
// 0 and at 2^WIDTH-1 instead of wrapping. A simultaneous push and pop
// cancel out, so the count holds.
//
// Ports:
//   clk   in   single clock; all state changes on its rising edge
//   rst   in   synchronous active-high reset, clears count to 0;
//              takes priority over push and pop
//   push  in   increment request (level, acts every cycle it is high)
//   pop   in   decrement request (level, acts every cycle it is high)
//   count out  [WIDTH-1:0] current value, straight from the register
//   full  out  high when count == 2^WIDTH-1 (decoded from the register)
//   empty out  high when count == 0 (decoded from the register)
module counter_k #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             at_zero;

    // Flags look only at the register, so they never glitch with the inputs.
    assign at_max  = (count_q == CNT_MAX);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (!at_max) begin
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (!at_zero) begin
                    count_d = count_q - CNT_ONE;
                end
            end
            // 2'b11 cancels, 2'b00 idles: both hold.
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = at_max;
    assign empty = at_zero;

endmodule

// File: tb/tb_counter_k.sv
module tb_counter_k;

    localparam int WIDTH = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;

    int vectors;
    int miscompares;
    int model;

    counter_k #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model by the
    // counter rules, then compare count/full/empty after the edge.
    task automatic step(input string tag, input logic r, input logic pu, input logic po);
        rst  = r;
        push = pu;
        pop  = po;
        @(posedge clk);
        if (r) model = 0;
        else if (pu && !po) model = (model < MAXV) ? model + 1 : MAXV;
        else if (po && !pu) model = (model > 0) ? model - 1 : 0;
        #1;
        check({tag, ".count"}, 32'(count), 32'(model));
        check({tag, ".full"},  32'(full),  32'(model == MAXV));
        check({tag, ".empty"}, 32'(empty), 32'(model == 0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model       = 0;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);

        // Reset with push held high: reset wins.
        step("reset", 1'b1, 1'b1, 1'b0);
        check("reset.count_const", 32'(count), 32'd0);

        // Count up to full.
        step("up1", 1'b0, 1'b1, 1'b0);
        check("up1.const", 32'(count), 32'd1);
        step("up2", 1'b0, 1'b1, 1'b0);
        check("up2.const", 32'(count), 32'd2);
        step("up3", 1'b0, 1'b1, 1'b0);
        check("up3.const", 32'(count), 32'd3);
        check("up3.full_const", 32'(full), 32'd1);

        // Overflow attempts saturate.
        step("ovf1", 1'b0, 1'b1, 1'b0);
        step("ovf2", 1'b0, 1'b1, 1'b0);
        check("ovf.const", 32'(count), 32'd3);

        // Pop held for 20 edges: 2,1,0 then stays at 0.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("down%0d", i), 1'b0, 1'b0, 1'b1);
        end
        check("down.const", 32'(count), 32'd0);
        check("down.empty_const", 32'(empty), 32'd1);

        // Simultaneous push and pop at 0, 1 and 3.
        step("both0", 1'b0, 1'b1, 1'b1);
        check("both0.const", 32'(count), 32'd0);
        step("to1", 1'b0, 1'b1, 1'b0);
        step("both1", 1'b0, 1'b1, 1'b1);
        check("both1.const", 32'(count), 32'd1);
        step("to2", 1'b0, 1'b1, 1'b0);
        step("to3", 1'b0, 1'b1, 1'b0);
        step("both3", 1'b0, 1'b1, 1'b1);
        check("both3.const", 32'(count), 32'd3);
        step("idle3", 1'b0, 1'b0, 1'b0);

        // Reset mid-run at count 2 with push, then resume counting.
        step("to2b", 1'b0, 1'b0, 1'b1);
        check("to2b.const", 32'(count), 32'd2);
        step("midrst", 1'b1, 1'b1, 1'b0);
        check("midrst.const", 32'(count), 32'd0);
        step("resume", 1'b0, 1'b1, 1'b0);
        check("resume.const", 32'(count), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
